// File: rtl/mul_pkg.sv
// Shared encodings for the RV32M multiply issue/result stage.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic MODE_SIGNED   = 1'b1;
    localparam logic MODE_UNSIGNED = 1'b0;

endpackage

// File: rtl/mul32.sv
// Combinational 32x32 multiplier; mode selects signed or unsigned operands.
module mul32 #(
    parameter real T = 0.150
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mode,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] p;

    if (T < 0.0) begin : g_bad_t
        $error("mul32: T must be non-negative");
    end

    // Sign extension to 64 bits makes a modular product exact for both modes
    assign ax = {{32{mode & a[31]}}, a};
    assign bx = {{32{mode & b[31]}}, b};
    assign p  = ax * bx;

    assign hi = p[63:32];
    assign lo = p[31:0];

endmodule

// File: rtl/mul_unit.sv
// Issue/result stage around mul32: registers one RV32M multiply,
// waits LAT cycles for the array to settle, then holds the result.
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned LAT  = 2,
    parameter int unsigned TAGW = 5,
    parameter real         T    = 0.150
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_res,
    output logic [TAGW-1:0] out_tag
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    if (LAT < 1 || LAT > 15) begin : g_bad_lat
        $error("mul_unit: LAT must be in 1..15");
    end

    state_e          state;
    state_e          state_n;
    logic [3:0]      cnt;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    op_e             op_q;
    logic [TAGW-1:0] tag_q;
    logic            accept;
    logic            mode;
    logic [31:0]     hi;
    logic [31:0]     lo;
    logic [31:0]     corr;
    logic [31:0]     res_sel;

    assign in_ready  = !rst && (state == IDLE ||
                                (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = BUSY;
            BUSY:    if (cnt == 4'd0) state_n = DONE;
            DONE:    if (out_ready) state_n = accept ? BUSY : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Operands only move on accept, so mul32 inputs are stable while BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_MUL;
            tag_q   <= '0;
            out_res <= '0;
            out_tag <= '0;
        end else begin
            if (accept) begin
                cnt   <= CNT_INIT;
                a_q   <= in_a;
                b_q   <= in_b;
                op_q  <= op_e'(in_op);
                tag_q <= in_tag;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == BUSY && cnt == 4'd0) begin
                out_res <= res_sel;
                out_tag <= tag_q;
            end
        end
    end

    assign mode = (op_q == OP_MULH) ? MODE_SIGNED : MODE_UNSIGNED;

    mul32 #(.T(T)) u_mul32 (
        .a    (a_q),
        .b    (b_q),
        .mode (mode),
        .hi   (hi),
        .lo   (lo)
    );

    // Signed rs1 times unsigned rs2: subtract b from the unsigned high word
    assign corr = a_q[31] ? b_q : '0;

    always_comb begin
        res_sel = '0;
        unique case (op_q)
            OP_MUL:    res_sel = lo;
            OP_MULH:   res_sel = hi;
            OP_MULHU:  res_sel = hi;
            OP_MULHSU: res_sel = hi - corr;
        endcase
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corners plus random traffic
// compared every cycle against a queue-based reference model.
module tb_mul_unit;

    localparam int LAT  = 2;
    localparam int TAGW = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_op = '0;
    logic [31:0]     in_a = '0;
    logic [31:0]     in_b = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     out_res;
    logic [TAGW-1:0] out_tag;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0]     res;
        logic [TAGW-1:0] tag;
        int              due;
    } exp_t;

    exp_t q[$];

    mul_unit #(.LAT(LAT), .TAGW(TAGW), .T(0.150)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Full 64-bit product from the RV32M operand interpretations
    function automatic logic [31:0] ref_mul(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        sa = {{32{a[31]}}, a};
        ua = {32'b0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (op)
            2'd0:    p = ua * ub;
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Compare process: model of what must be visible on this cycle
    always @(negedge clk) begin
        logic ev;
        logic er;
        exp_t e;
        cyc++;
        if (rst) begin
            q.delete();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
        end else begin
            ev = (q.size() > 0) && (q[0].due <= cyc);
            chk("out_valid", out_valid, ev);
            if (ev) begin
                chk("out_res", out_res, q[0].res);
                chk("out_tag", out_tag, q[0].tag);
            end
            er = (q.size() == 0) || (ev && out_ready);
            chk("in_ready", in_ready, er);
            if (ev && out_ready) void'(q.pop_front());
            if (in_valid && er) begin
                e.res = ref_mul(in_op, in_a, in_b);
                e.tag = in_tag;
                e.due = cyc + LAT + 1;
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAGW-1:0] tag);
        bit ok;
        ok = 0;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("issue_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_res(input string name, input logic [31:0] exp);
        bit got;
        got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        else chk(name, out_res, exp);
        @(posedge clk);
        #1;
    endtask

    logic [1:0]  t_op[7]  = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd2};
    logic [31:0] t_a[7]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                              32'h8000_0000};
    logic [31:0] t_b[7]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2};
    logic [31:0] t_exp[7] = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
                              32'hFFFF_FFFF};

    initial begin
        int prev;
        repeat (2) @(negedge clk);
        chk("reset_out_res", out_res, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_out_valid", out_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 7; i++)
            chk($sformatf("model_pin_%0d", i),
                ref_mul(t_op[i], t_a[i], t_b[i]), t_exp[i]);
        chk("model_pin_mul", ref_mul(2'd0, 32'd292, 32'd6785), 32'd1981220);

        issue(2'd0, 32'd292, 32'd6785, 5'd3);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("lat_low", out_valid, 0);
        end
        @(negedge clk);
        chk("lat_high", out_valid, 1);
        chk("first_res", out_res, 32'd1981220);
        chk("first_tag", out_tag, 3);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            issue(t_op[i], t_a[i], t_b[i], 5'(i));
            wait_res($sformatf("corner_%0d", i), t_exp[i]);
        end

        out_ready = 1'b0;
        issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        wait_res("bp_first", 32'hFFFF_FFFE);
        in_op = 2'd0;
        in_a = 32'd10;
        in_b = 32'd20;
        in_tag = 5'd9;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_res", out_res, 32'hFFFF_FFFE);
            chk("bp_hold_tag", out_tag, 7);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_same_edge_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("bp_lat_low", out_valid, 0);
        end
        @(negedge clk);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_res", out_res, 200);
        chk("bp_next_tag", out_tag, 9);
        @(posedge clk);
        #1;

        prev = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_op = 2'($urandom);
            in_a = pick();
            in_b = pick();
            in_tag = 5'($urandom);
            @(negedge clk);
            if (out_valid) begin
                if (prev >= 0) chk("stream_gap", 32'(i - prev), LAT + 1);
                prev = i;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1;

        issue(2'd1, 32'd5, 32'd7, 5'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("rst_discard", out_valid, 0);
        end

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_op = 2'($urandom);
            in_a = pick();
            in_b = pick();
            in_tag = 5'($urandom);
            rst = ($urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
